// File: rtl/reg_file_wb_pkg.sv
// Shared constants, types and helpers for the write-back register file.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
package reg_file_wb_pkg;

    localparam int XLEN    = 64;
    localparam int NREG    = 32;
    localparam int AW      = 5;
    localparam int CW      = 2;
    localparam int CNT_MAX = 3;

    typedef logic [CW-1:0]   cnt_t;
    typedef logic [AW-1:0]   idx_t;
    typedef logic [XLEN-1:0] data_t;

    localparam idx_t ZERO_REG = '0;

    // A source is ready when it has no pending writer, or when its last pending
    // writer is retiring in this very cycle (the value arrives via the bypass).
    function automatic logic src_ready(input cnt_t cnt, input idx_t rs,
                                       input logic wr, input idx_t rd);
        return (rs == ZERO_REG) || (cnt == '0) ||
               ((cnt == cnt_t'(1)) && wr && (rd == rs));
    endfunction

endpackage

// File: rtl/reg_file_wb_if.sv
// Decode / write-back / cancel bundle between the pipeline and the register file.
// Latency: n/a (wires only).
// Backpressure: StallD flows from slave to master and holds decode.
// Ports: master = pipeline side, slave = register file side.
interface reg_file_wb_if;
    import reg_file_wb_pkg::*;

    logic  RegWriteW;
    idx_t  RdW;
    data_t ResultW;
    idx_t  Rs1D;
    idx_t  Rs2D;
    logic  UseRs1D;
    logic  UseRs2D;
    logic  IssueD;
    logic  RegWriteD;
    idx_t  RdD;
    logic  CancelE;
    idx_t  CancelRdE;
    data_t RD1D;
    data_t RD2D;
    logic  StallD;
    logic  SbErr;

    modport master (
        output RegWriteW, RdW, ResultW, Rs1D, Rs2D, UseRs1D, UseRs2D,
               IssueD, RegWriteD, RdD, CancelE, CancelRdE,
        input  RD1D, RD2D, StallD, SbErr
    );

    modport slave (
        input  RegWriteW, RdW, ResultW, Rs1D, Rs2D, UseRs1D, UseRs2D,
               IssueD, RegWriteD, RdD, CancelE, CancelRdE,
        output RD1D, RD2D, StallD, SbErr
    );

endinterface

// File: rtl/reg_file_wb_sb_counter.sv
// Saturating pending-writer counter for one register (+1 issue, -0..2 retire/cancel).
// Latency: count updates at the next rising edge; ovf/udf are same-cycle combinational.
// Backpressure: none; out-of-range results clamp to [0, CNT_MAX] and pulse ovf/udf.
// Ports: clk, rst_n (sync, active-low), inc, dec[1:0] -> cnt, ovf, udf.
module sb_counter
    import reg_file_wb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic [1:0] dec,
    output cnt_t       cnt,
    output logic       ovf,
    output logic       udf
);

    // Two extra bits: one for the sign, one for headroom above CNT_MAX.
    localparam logic signed [CW+1:0] MAX_S = (CW+2)'(CNT_MAX);

    cnt_t                   cnt_q, cnt_d;
    logic signed [CW+1:0]   net;

    always_comb begin
        net   = $signed({2'b00, cnt_q})
              + $signed({{(CW+1){1'b0}}, inc})
              - $signed({{CW{1'b0}}, dec});
        ovf   = (net > MAX_S);
        udf   = (net < 0);
        cnt_d = net[CW-1:0];
        if (ovf) begin
            cnt_d = cnt_t'(CNT_MAX);
        end else if (udf) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/reg_file_wb.sv
// Integer register file with write-first WB bypass and per-register pending-writer scoreboard.
// Latency: reads, bypass and StallD are combinational; writes/counters update at the next edge.
// Backpressure: StallD holds decode while a used source still has an unretired producer.
// Ports: clock, reset (sync, active-low), bus (reg_file_wb_if.slave).
module reg_file_wb
    import reg_file_wb_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    reg_file_wb_if.slave  bus
);

    data_t            regs_q [NREG];
    data_t            regs_d [NREG];
    logic             sb_err_q, sb_err_d;
    cnt_t             cnt_arr [NREG];
    logic [NREG-1:0]  ovf_vec, udf_vec;

    logic             retire, cancel, issue_fire;
    logic             ready1, ready2;

    assign retire = bus.RegWriteW && (bus.RdW != ZERO_REG);
    assign cancel = bus.CancelE && (bus.CancelRdE != ZERO_REG);

    assign ready1 = src_ready(cnt_arr[bus.Rs1D], bus.Rs1D, bus.RegWriteW, bus.RdW);
    assign ready2 = src_ready(cnt_arr[bus.Rs2D], bus.Rs2D, bus.RegWriteW, bus.RdW);

    // Stall is masked by reset so pending counts stop blocking decode immediately.
    assign bus.StallD = reset && ((bus.UseRs1D && !ready1) || (bus.UseRs2D && !ready2));

    assign issue_fire = bus.IssueD && !bus.StallD && bus.RegWriteD && (bus.RdD != ZERO_REG);

    for (genvar r = 0; r < NREG; r++) begin : g_sb
        logic       inc;
        logic [1:0] dec;
        logic       ret_hit, can_hit;

        assign inc     = issue_fire && (bus.RdD == idx_t'(r));
        assign ret_hit = retire && (bus.RdW == idx_t'(r));
        assign can_hit = cancel && (bus.CancelRdE == idx_t'(r));
        // Retire and cancel on the same register in one cycle count as -2.
        assign dec     = {ret_hit && can_hit, ret_hit ^ can_hit};

        sb_counter u_cnt (
            .clk   (clock),
            .rst_n (reset),
            .inc   (inc),
            .dec   (dec),
            .cnt   (cnt_arr[r]),
            .ovf   (ovf_vec[r]),
            .udf   (udf_vec[r])
        );
    end

    always_comb begin
        regs_d = regs_q;
        if (retire) begin
            regs_d[bus.RdW] = bus.ResultW;
        end
        sb_err_d = sb_err_q || (|ovf_vec) || (|udf_vec);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            sb_err_q <= sb_err_d;
        end
    end

    // Write-first read: x0 reads zero, a same-cycle write-back wins over the array.
    always_comb begin
        bus.RD1D = '0;
        if (reset && (bus.Rs1D != ZERO_REG)) begin
            bus.RD1D = (bus.RegWriteW && (bus.RdW == bus.Rs1D)) ? bus.ResultW : regs_q[bus.Rs1D];
        end
        bus.RD2D = '0;
        if (reset && (bus.Rs2D != ZERO_REG)) begin
            bus.RD2D = (bus.RegWriteW && (bus.RdW == bus.Rs2D)) ? bus.ResultW : regs_q[bus.Rs2D];
        end
    end

    assign bus.SbErr = sb_err_q;

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed self-checking bench for reg_file_wb.
// Latency: checks combinational outputs 3 time units after each rising edge.
// Backpressure: StallD is checked directly against hand-computed expectations.
module tb_reg_file_wb;
    import reg_file_wb_pkg::*;

    logic clock;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    reg_file_wb_if bus();

    reg_file_wb dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        bus.RegWriteW = 1'b0;
        bus.RdW       = '0;
        bus.ResultW   = '0;
        bus.Rs1D      = '0;
        bus.Rs2D      = '0;
        bus.UseRs1D   = 1'b0;
        bus.UseRs2D   = 1'b0;
        bus.IssueD    = 1'b0;
        bus.RegWriteD = 1'b0;
        bus.RdD       = '0;
        bus.CancelE   = 1'b0;
        bus.CancelRdE = '0;
    endtask

    task automatic issue(input idx_t rd);
        idle();
        bus.IssueD    = 1'b1;
        bus.RegWriteD = 1'b1;
        bus.RdD       = rd;
        step();
    endtask

    initial begin
        idle();
        reset = 1'b0;

        // Reset: write/issue on x5 must be ignored, outputs forced low.
        bus.RegWriteW = 1'b1; bus.RdW = 5'd5; bus.ResultW = 64'd1;
        bus.Rs1D = 5'd5; bus.UseRs1D = 1'b1;
        bus.IssueD = 1'b1; bus.RegWriteD = 1'b1; bus.RdD = 5'd5;
        settle();
        check("rst_rd1_during", bus.RD1D, 64'd0);
        check("rst_stall_during", {63'd0, bus.StallD}, 64'd0);
        step(); step();
        reset = 1'b1;
        idle(); bus.Rs1D = 5'd5; bus.UseRs1D = 1'b1;
        settle();
        check("rst_rd1", bus.RD1D, 64'd0);
        check("rst_stall", {63'd0, bus.StallD}, 64'd0);
        check("rst_sberr", {63'd0, bus.SbErr}, 64'd0);

        // Write and read back.
        idle(); bus.RegWriteW = 1'b1; bus.RdW = 5'd10; bus.ResultW = 64'hAABBCCDDEEFF0011;
        step();
        idle(); bus.Rs1D = 5'd10; settle();
        check("rd_x10", bus.RD1D, 64'hAABBCCDDEEFF0011);

        // x0 is never written or bypassed.
        idle(); bus.RegWriteW = 1'b1; bus.RdW = 5'd0; bus.ResultW = '1; bus.Rs2D = 5'd0;
        settle();
        check("x0_bypass", bus.RD2D, 64'd0);
        step();
        idle(); bus.Rs2D = 5'd0; settle();
        check("x0_read", bus.RD2D, 64'd0);

        // Write-first bypass.
        idle(); bus.RegWriteW = 1'b1; bus.RdW = 5'd21; bus.ResultW = 64'h123456789ABCDEF0;
        bus.Rs2D = 5'd21; settle();
        check("bypass_rd2", bus.RD2D, 64'h123456789ABCDEF0);
        step();
        idle(); bus.Rs2D = 5'd21; settle();
        check("x21_stored", bus.RD2D, 64'h123456789ABCDEF0);

        // Single writer stall and release.
        idle(); bus.IssueD = 1'b1; bus.RegWriteD = 1'b1; bus.RdD = 5'd7; settle();
        check("issue7_nostall", {63'd0, bus.StallD}, 64'd0);
        step();
        idle(); bus.UseRs1D = 1'b1; bus.Rs1D = 5'd7; settle();
        check("x7_stall", {63'd0, bus.StallD}, 64'd1);
        bus.RegWriteW = 1'b1; bus.RdW = 5'd7; bus.ResultW = 64'h44; settle();
        check("x7_release", {63'd0, bus.StallD}, 64'd0);
        check("x7_bypass", bus.RD1D, 64'h44);
        step();
        bus.RegWriteW = 1'b0; settle();
        check("x7_clear", {63'd0, bus.StallD}, 64'd0);
        check("x7_value", bus.RD1D, 64'h44);

        // A stalled issue must not create a pending writer.
        issue(5'd7);
        idle(); bus.UseRs1D = 1'b1; bus.Rs1D = 5'd7;
        bus.IssueD = 1'b1; bus.RegWriteD = 1'b1; bus.RdD = 5'd8; settle();
        check("stalled_issue", {63'd0, bus.StallD}, 64'd1);
        step();
        idle(); bus.UseRs1D = 1'b1; bus.Rs1D = 5'd8; settle();
        check("x8_not_pending", {63'd0, bus.StallD}, 64'd0);
        idle(); bus.RegWriteW = 1'b1; bus.RdW = 5'd7; bus.ResultW = 64'h55; step();

        // Two writers on x3, retired one after the other.
        issue(5'd3); issue(5'd3);
        idle(); bus.UseRs1D = 1'b1; bus.Rs1D = 5'd3; settle();
        check("x3_cnt2_stall", {63'd0, bus.StallD}, 64'd1);
        bus.RegWriteW = 1'b1; bus.RdW = 5'd3; bus.ResultW = 64'h31; settle();
        check("x3_first_wb", {63'd0, bus.StallD}, 64'd1);
        step();
        bus.RegWriteW = 1'b0; settle();
        check("x3_cnt1_stall", {63'd0, bus.StallD}, 64'd1);
        bus.RegWriteW = 1'b1; bus.ResultW = 64'h32; settle();
        check("x3_second_wb", {63'd0, bus.StallD}, 64'd0);
        check("x3_bypass", bus.RD1D, 64'h32);
        step();
        bus.RegWriteW = 1'b0; settle();
        check("x3_clear", {63'd0, bus.StallD}, 64'd0);
        check("x3_value", bus.RD1D, 64'h32);

        // Second writer cancelled instead of retired.
        issue(5'd3); issue(5'd3);
        idle(); bus.RegWriteW = 1'b1; bus.RdW = 5'd3; bus.ResultW = 64'h33; step();
        idle(); bus.UseRs1D = 1'b1; bus.Rs1D = 5'd3; settle();
        check("x3_pre_cancel", {63'd0, bus.StallD}, 64'd1);
        bus.CancelE = 1'b1; bus.CancelRdE = 5'd3; settle();
        check("x3_cancel_comb", {63'd0, bus.StallD}, 64'd1);
        step();
        bus.CancelE = 1'b0; settle();
        check("x3_cancelled", {63'd0, bus.StallD}, 64'd0);

        // Retire and cancel together on the same register subtract two.
        issue(5'd3); issue(5'd3);
        idle(); bus.RegWriteW = 1'b1; bus.RdW = 5'd3; bus.ResultW = 64'h34;
        bus.CancelE = 1'b1; bus.CancelRdE = 5'd3; step();
        idle(); bus.UseRs1D = 1'b1; bus.Rs1D = 5'd3; settle();
        check("x3_ret_cancel", {63'd0, bus.StallD}, 64'd0);

        // Overflow: four issues saturate at three and flag the error.
        reset = 1'b0; idle(); step(); reset = 1'b1; settle();
        check("ovf_sberr_clear", {63'd0, bus.SbErr}, 64'd0);
        idle(); bus.Rs2D = 5'd10; settle();
        check("rst_cleared_x10", bus.RD2D, 64'd0);
        issue(5'd9); issue(5'd9); issue(5'd9);
        idle(); settle();
        check("three_issues_ok", {63'd0, bus.SbErr}, 64'd0);
        issue(5'd9);
        idle(); settle();
        check("ovf_sberr", {63'd0, bus.SbErr}, 64'd1);
        bus.RegWriteW = 1'b1; bus.RdW = 5'd9; bus.ResultW = 64'h99; step(); step();
        bus.RegWriteW = 1'b0; bus.UseRs1D = 1'b1; bus.Rs1D = 5'd9; settle();
        check("x9_sat_stall", {63'd0, bus.StallD}, 64'd1);
        bus.RegWriteW = 1'b1; step();
        bus.RegWriteW = 1'b0; settle();
        check("x9_sat_clear", {63'd0, bus.StallD}, 64'd0);

        // Underflow: retire with no pending writer still writes data.
        reset = 1'b0; idle(); step(); reset = 1'b1; settle();
        check("udf_sberr_clear", {63'd0, bus.SbErr}, 64'd0);
        idle(); bus.RegWriteW = 1'b1; bus.RdW = 5'd12; bus.ResultW = 64'h1212; step();
        idle(); bus.Rs1D = 5'd12; settle();
        check("udf_x12_written", bus.RD1D, 64'h1212);
        check("udf_sberr", {63'd0, bus.SbErr}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- Integer register file at the consuming end of the write-back interface (RegWriteW/RdW/ResultW) of the 64-bit RISC-V pipeline.
- Provides two decode-stage read ports with write-first bypass from the WB stage.
- Contains a per-register pending-write scoreboard. It raises a decode stall whenever a source operand still has an in-flight producer that is not being written back this cycle.

Parameters:
XLEN, 64, data width of registers and ports
NREG, 32, number of architectural registers (x0 hardwired zero)
AW, 5, register index width (log2 NREG)
CW, 2, scoreboard counter width per register (max 3 in-flight writers)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous reset, active-low (0 = reset)
RegWriteW  in  1  write-back enable
RdW  in  AW  write-back destination index
ResultW  in  XLEN  write-back data
Rs1D  in  AW  decode source 1 index
Rs2D  in  AW  decode source 2 index
UseRs1D  in  1  decode instruction reads Rs1
UseRs2D  in  1  decode instruction reads Rs2
IssueD  in  1  decode instruction requests to advance
RegWriteD  in  1  decode instruction will write Rd
RdD  in  AW  decode destination index
CancelE  in  1  instruction in Execute is flushed
CancelRdE  in  AW  destination index of the flushed instruction (only valid with CancelE and its RegWrite)
RD1D  out  XLEN  source 1 data
RD2D  out  XLEN  source 2 data
StallD  out  1  decode must hold
SbErr  out  1  sticky scoreboard over/underflow flag

Behaviour:
- Reset (reset=0 at a rising edge):
  - All registers are cleared to 0, all counters to 0, and SbErr to 0.
  - While reset=0: RD1D=RD2D=0, StallD=0, and every write, issue and cancel is ignored.
- Write: at a rising edge with RegWriteW=1 and RdW!=0, reg[RdW] <= ResultW. A write with RdW==0 is discarded.
- Read (combinational):
  - RDn = 0 if Rsn==0.
  - Otherwise RDn = ResultW if RegWriteW and RdW==Rsn (write-first bypass).
  - Otherwise RDn = reg[Rsn].
- Ready rule: source n is ready when cnt[Rsn]==0, OR when cnt[Rsn]==1 and RegWriteW and RdW==Rsn. Index 0 is always ready.
- StallD = (UseRs1D & !ready1) | (UseRs2D & !ready2). It is purely combinational, with no added latency.
- Issue event: IssueD & !StallD & RegWriteD & RdD!=0 adds +1 to cnt[RdD]. A stalled issue has no effect.
- Retire event: RegWriteW & RdW!=0 adds -1 to cnt[RdW].
- Cancel event: CancelE & CancelRdE!=0 adds -1 to cnt[CancelRdE]. The control logic asserts CancelE only for flushed instructions that had RegWrite.
- Simultaneous events: all deltas to the same register are summed in one cycle. For example, issue+retire on the same register leaves it unchanged; retire+cancel on the same register gives -2.
- Overflow: if the net result would exceed 3, the counter saturates at 3 and SbErr <= 1.
- Underflow: if the net result would drop below 0, the counter clamps at 0 and SbErr <= 1. The data write still happens.
- SbErr is sticky until reset.
- Reset asserted mid-operation: all pending counts are discarded and stall drops immediately (same cycle, combinational on reset).
- There is no other FSM. State consists of NREG×XLEN data bits, NREG×CW counters and the SbErr bit.

Decomposition:
- Shared package holds:
  - XLEN/AW/NREG constants
  - ZERO_REG=0
  - CNT_MAX=3
  - a typedef for the counter width
- Natural sub-module: sb_counter (one instance per register). It takes inc and dec[1:0] and produces a saturating count plus ovf/udf pulses.
- reg_file_wb contains the array, the bypass and the stall logic.

Test Plan:
- Reset: hold reset=0 for 2 cycles while driving RegWriteW=1, RdW=5, ResultW=1. Then read Rs1D=5 → RD1D=0, StallD=0, SbErr=0.
- Write/read:
  - Write x10=64'hAABBCCDDEEFF0011, then read Rs1D=10 the next cycle → RD1D=AABBCCDDEEFF0011.
  - Write x0=64'hFFFF… then read Rs2D=0 → RD2D=0.
- Bypass: in the same cycle drive RegWriteW=1, RdW=21, ResultW=64'h123456789ABCDEF0 and Rs2D=21 → RD2D=123456789ABCDEF0 combinationally.
- Stall/release:
  - Issue RdD=7. Next cycle use Rs1D=7 → StallD=1.
  - In the cycle with RegWriteW, RdW=7, ResultW=0x44 → StallD=0 and RD1D=0x44.
- Double writer:
  - Issue RdD=3 twice (count=2). First write-back of x3 → StallD remains 1.
  - Second write-back → StallD=0.
  - A cancel with CancelRdE=3 instead of the second write-back also clears the count.
- Errors:
  - Issue RdD=9 four times without retire → count stays 3, SbErr=1.
  - After reset, write-back RdW=12 with count 0 → x12 is written and SbErr=1.
